// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M iterative multiply/divide unit.
// The opcode values are also used by the instruction decoder that drives op_i.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // Wide constants; the unit slices them down to its own WIDTH.
    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] ALL_ONES_MAX = '1;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with register-file write-back outputs.
//
//  state | meaning
//  IDLE  | waiting for start_i; operands latched on acceptance
//  CALC  | one multiply/divide step per cycle, counter 0..WIDTH-1
//  DONE  | one-cycle result pulse; write-back registers already loaded
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  wd_o,
    output logic [ADDR_W-1:0] wd_addr_o,
    output logic              we_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = ALL_ONES_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MOST_NEG = ~(ALL_ONES >> 1);

    muldiv_state_t r_state, w_state_nxt;

    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [ADDR_W-1:0]  r_rd;
    logic               r_neg;
    logic               r_rem_neg;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_wd;
    logic [ADDR_W-1:0]  r_wd_addr;

    logic               w_accept, w_a_sgn, w_b_sgn, w_special;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_special_res;
    logic [WIDTH-1:0]   w_add, w_quot, w_rem;
    logic [WIDTH:0]     w_sum, w_rs, w_diff;
    logic [2*WIDTH-1:0] w_acc_nxt, w_prod_fix;
    logic [WIDTH-1:0]   w_result;

    assign w_accept = (r_state == IDLE) && start_i;

    // Sign of each operand only matters for the signed flavours.
    assign w_a_sgn = a_i[WIDTH-1] &&
                     (op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM);
    assign w_b_sgn = b_i[WIDTH-1] &&
                     (op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM);
    assign w_a_mag = w_a_sgn ? -a_i : a_i;
    assign w_b_mag = w_b_sgn ? -b_i : b_i;

    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (op_i[2] && b_i == '0) begin
            w_special     = 1'b1;
            w_special_res = op_i[1] ? a_i : ALL_ONES;
        end else if (!op_i[0] && op_i[2] && a_i == MOST_NEG && b_i == ALL_ONES) begin
            w_special     = 1'b1;
            w_special_res = op_i[1] ? '0 : MOST_NEG;
        end
    end

    // Multiply step: add multiplicand into the high half, shift right.
    assign w_add = r_acc[0] ? r_b : '0;
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_add};
    // Divide step: shift {rem,quot} left, trial-subtract divisor from rem.
    assign w_rs   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff = w_rs - {1'b0, r_b};

    always_comb begin
        if (!r_op[2])
            w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        else if (w_diff[WIDTH])
            w_acc_nxt = {w_rs[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        else
            w_acc_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end

    assign w_prod_fix = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_quot     = r_neg ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    assign w_rem      = r_rem_neg ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        case (r_op)
            OP_MUL:                     w_result = w_prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   w_result = w_prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:            w_result = w_quot;
            default:                    w_result = w_rem;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_nxt = w_special ? DONE : CALC;
            CALC:    if (r_cnt == CNT_LAST) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_rd      <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_b       <= '0;
            r_acc     <= '0;
            r_wd      <= '0;
            r_wd_addr <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_op      <= op_i;
            r_rd      <= rd_addr_i;
            r_neg     <= w_a_sgn ^ w_b_sgn;
            r_rem_neg <= w_a_sgn;
            r_b       <= w_b_mag;
            r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
            if (w_special) begin
                r_wd      <= w_special_res;
                r_wd_addr <= rd_addr_i;
            end
        end else if (r_state == CALC) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CNT_LAST) begin
                r_wd      <= w_result;
                r_wd_addr <= r_rd;
            end
        end
    end

    assign busy_o    = (r_state != IDLE);
    assign done_o    = (r_state == DONE);
    assign wd_o      = r_wd;
    assign wd_addr_o = r_wd_addr;
    assign we_o      = done_o && (r_wd_addr != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random operations checked
// against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        busy_o, done_o, we_o;
    logic [31:0] wd_o;
    logic [4:0]  wd_addr_o;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .rd_addr_i(rd_addr_i), .busy_o(busy_o),
        .done_o(done_o), .wd_o(wd_o), .wd_addr_o(wd_addr_o), .we_o(we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa, sb, ub, p;
        logic [63:0] up;
        int ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ub = {32'h0, b};
        ia = a;
        ib = b;
        case (op)
            OP_MUL:    begin up = {32'h0, a} * {32'h0, b}; return up[31:0];  end
            OP_MULH:   begin p = sa * sb; up = p; return up[63:32]; end
            OP_MULHSU: begin p = sa * ub; up = p; return up[63:32]; end
            OP_MULHU:  begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            OP_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                       else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                       else return ia / ib;
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    if (b == 0) return a;
                       else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                       else return ia % ib;
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Start one operation and follow it to its result pulse.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp;
        int exp_lat, lat;
        bit busy_ok, special;
        exp = ref_model(op, a, b);
        special = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp_lat = special ? 1 : 33;
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_addr_i = rd;
        @(negedge clk_i);
        start_i = 1'b0;
        a_i = $urandom; b_i = $urandom; op_i = 3'($urandom); rd_addr_i = 5'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!done_o && lat < 100) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            @(negedge clk_i);
            lat++;
        end
        check({tag, " done"}, {63'h0, done_o}, 64'h1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_while_calc"}, {63'h0, busy_ok}, 64'h1);
        check({tag, " busy_in_done"}, {63'h0, busy_o}, 64'h1);
        check({tag, " wd"}, wd_o, exp);
        check({tag, " wd_addr"}, wd_addr_o, rd);
        check({tag, " we"}, {63'h0, we_o}, {63'h0, rd != 0});
        @(negedge clk_i);
        check({tag, " idle_after"}, {62'h0, busy_o, done_o}, 64'h0);
        check({tag, " wd_hold"}, wd_o, exp);
    endtask

    initial begin
        int dones;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        repeat (2) @(negedge clk_i);
        check("reset outputs", {busy_o, done_o, we_o, wd_o, wd_addr_o}, 64'h0);
        reset_i = 1'b1;
        @(negedge clk_i);

        do_op("mul",      OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5);
        check("mul literal", wd_o, 32'hFFFF_FFEB);
        do_op("mulhu",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        check("mulhu literal", wd_o, 32'hFFFF_FFFE);
        do_op("mulh",     OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        do_op("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd3);
        check("mulhsu literal", wd_o, 32'hFFFF_FFFF);
        do_op("div",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4);
        check("div literal", wd_o, 32'hFFFF_FFFD);
        do_op("rem",      OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd6);
        check("rem literal", wd_o, 32'hFFFF_FFFF);
        do_op("divu",     OP_DIVU,   32'd100,       32'd7,         5'd7);
        do_op("remu",     OP_REMU,   32'd100,       32'd7,         5'd8);
        do_op("div0",     OP_DIV,    32'd5,         32'd0,         5'd9);
        do_op("rem0",     OP_REM,    32'd5,         32'd0,         5'd10);
        check("rem0 literal", wd_o, 32'd5);
        do_op("divu0",    OP_DIVU,   32'd5,         32'd0,         5'd11);
        do_op("remu0",    OP_REMU,   32'd77,        32'd0,         5'd12);
        do_op("div_ovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        check("div_ovf literal", wd_o, 32'h8000_0000);
        do_op("rem_ovf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
        do_op("x0_write", OP_MUL,    32'd3,         32'd4,         5'd0);

        // Second start while calculating must be ignored.
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd50; b_i = 32'd5; rd_addr_i = 5'd15;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        start_i = 1'b1; op_i = OP_MUL; a_i = 32'd9; b_i = 32'd9; rd_addr_i = 5'd16;
        @(negedge clk_i);
        start_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            if (done_o) begin
                dones++;
                check("restart wd", wd_o, 32'd10);
                check("restart addr", wd_addr_o, 5'd15);
            end
            @(negedge clk_i);
        end
        check("restart done count", dones, 1);

        // Reset mid-calculation at counter value 10.
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_MUL; a_i = 32'd1234; b_i = 32'd5678; rd_addr_i = 5'd17;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("abort outputs", {busy_o, done_o, we_o, wd_o, wd_addr_o}, 64'h0);
        @(negedge clk_i);
        reset_i = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) dones++;
            @(negedge clk_i);
        end
        check("abort no done", dones, 0);
        do_op("divu_after_rst", OP_DIVU, 32'd9, 32'd3, 5'd18);
        check("divu_after_rst literal", wd_o, 32'd3);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), rop, ra, rb, 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
